ac97_frame_ctl: RTL
===================

# ac97_frame_ctl

AC97 link frame sequencer driving the serial input capture block. Runs a 256-bit frame counter on the bit clock, generates the SYNC frame marker and the per-slot latch enables `out_le[4:0]` for slots 0–4. It also sequences clean start/stop of the link and reports frame completion and codec-ready status to the register layer.

## Interface
- `IN_DLY`, 2, bit-clock cycles from a slot's last bit on the wire to that slot being complete in the shift register; legal range 0–3.
- `clk` input 1: AC97 bit clock; all logic is on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: link run request, level-sensitive.
- `codec_rdy_in` input 1: slot 0 tag bit 15 (codec ready) from the capture block's `slt0[15]`.
- `sync` output 1: registered AC97 SYNC.
- `out_le` output 5: one-cycle latch strobes for slots 0–4 in the capture block.
- `frame_done` output 1: one-cycle pulse at the end of every completed frame.
- `running` output 1: high while frames are being sequenced.
- `codec_ready` output 1: latched codec-ready flag.
- `frame_cnt` output 8: count of completed frames, wraps 255→0.

## Operation
- The state machine has three states: IDLE, RUN and STOP.
  - IDLE: `cnt` is held at 0. `sync`, `out_le`, `frame_done` and `running` are all low. When `en`=1, go to RUN; the next cycle is `cnt`=0 of frame 1.
  - RUN: `cnt` increments by 1 each cycle, 0..255, with mod-256 wrap. If `en`=0 is seen with `cnt`≠255, go to STOP. If `en`=0 is seen at `cnt`=255, go directly to IDLE.
  - STOP: the current frame finishes normally, with all strobes still generated. At `cnt`=255, go to IDLE. If `en` returns to 1 during STOP, go back to RUN with no gap.
- `running` is 1 in RUN and STOP.
- `sync` is 1 for `cnt`=0..15 of each frame while `running`, and 0 otherwise.
- Slot boundaries: slot 0 is bits 0–15. Slot n (n=1..4) is bits 16+20(n−1) through 15+20n.
- `out_le[s]` pulses for one cycle when `cnt` = (last bit of slot s) + `IN_DLY`:
  - With the default: s0 at 17, s1 at 37, s2 at 57, s3 at 77, s4 at 97.
  - At most one `out_le` bit is high in any cycle.
- `frame_done` pulses at `cnt`=255 of every frame, including the frame closed by STOP.
- `frame_cnt` increments at the same time as `frame_done`.
- `codec_ready` is updated to `codec_rdy_in` in the cycle after `out_le[0]`. It holds its value otherwise, including in IDLE.
- Unused `cnt` values (98..254) produce no strobes.

## Timing
- Reset values:
  - state IDLE and `cnt`=0.
  - `sync`, `out_le`, `frame_done`, `running` and `codec_ready` are 0.
  - `frame_cnt` is 0.
- All outputs are registered and change only on posedge `clk`, except when `rst` asserts.
- Latency:
  - `en` rising in IDLE gives `running`=1 and `sync`=1 on the next edge.
  - `sync` falls at the edge that makes `cnt`=16.
- Reset mid-frame: all outputs clear immediately and no partial `frame_done` is produced. After `rst` is released, the block waits in IDLE for `en`.
- `en` is sampled every cycle. Toggles shorter than a frame never truncate a frame once RUN has started.
- `frame_cnt` wrap: 255 + 1 → 0, with no flag.
- An `out_le` strobe and `frame_done` never coincide, because the strobe positions are at most 100.

## Test plan
- Reset then `en`=1 and held → `sync` high for 16 cycles every 256 cycles. `out_le` one-hots at `cnt` 17/37/57/77/97. `frame_done` at 255. `frame_cnt`=3 after 3 frames.
- `en` dropped at `cnt`=40 → s2–s4 strobes still occur. `frame_done` pulses at 255, then `running`=0 and `sync` stays 0.
- `en` dropped at `cnt`=100 and reasserted at `cnt`=200 → the next frame starts immediately after 255, with no idle cycle.
- `codec_rdy_in`=1 presented around `cnt`=17 → `codec_ready`=1 at `cnt`=18. `codec_rdy_in`=0 next frame → `codec_ready`=0 after that frame's `out_le[0]`.
- `rst` pulsed at `cnt`=60 → all outputs are 0 asynchronously and `frame_cnt`=0. After release with `en`=1, a new frame starts at `cnt`=0.
- `IN_DLY`=0 build → strobes at 15/35/55/75/95. Run 257 frames → `frame_cnt` wraps to 1.

Source files
------------

// File: rtl/ac97_frame_ctl.sv
// AC97 link frame sequencer: 256-bit frame counter, SYNC, slot 0-4 latch
// strobes, clean start/stop, frame completion count and codec-ready flag.
module ac97_frame_ctl #(
    parameter int IN_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       codec_rdy_in,
    output logic       sync,
    output logic [4:0] out_le,
    output logic       frame_done,
    output logic       running,
    output logic       codec_ready,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       act_d;
    logic       end_d;
    logic [4:0] le_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (cnt_q == 8'hff) state_d = en ? RUN : IDLE;
                else if (!en)       state_d = STOP;
            end
            STOP: begin
                if (cnt_q == 8'hff) state_d = en ? RUN : IDLE;
                else if (en)        state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        // A frame always starts at bit 0, whichever way it is entered
        if (state_q == IDLE || state_d == IDLE) cnt_d = 8'd0;
    end

    assign act_d = (state_d != IDLE);
    assign end_d = act_d && (cnt_d == 8'hff);

    // Strobe when the slot's last bit has reached the shift register
    always_comb begin
        le_d = 5'd0;
        for (int s = 0; s < 5; s++) begin
            le_d[s] = act_d && (cnt_d == 8'(15 + 20 * s + IN_DLY));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            sync        <= 1'b0;
            out_le      <= 5'd0;
            frame_done  <= 1'b0;
            running     <= 1'b0;
            codec_ready <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            running    <= act_d;
            sync       <= act_d && (cnt_d < 8'd16);
            out_le     <= le_d;
            frame_done <= end_d;
            if (end_d)     frame_cnt   <= frame_cnt + 8'd1;
            if (out_le[0]) codec_ready <= codec_rdy_in;
        end
    end

endmodule
